rv_alu_seq: RTL and testbench

Parametrised, sequential successor to the core's combinational ALU. It keeps the legacy 4-bit operation codes, adds XOR, shifts and signed compare, and adds an iterative RV M-extension multiply/divide unit. Operations are accepted and returned through valid/ready handshakes. It sits in the execute stage; the pipeline stalls on `ready_o` low.

---
 rtl/rv_alu_seq.sv | 168 ++++++++++++++++
 tb/tb_rv_alu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rv_alu_seq.sv
// Sequential ALU with legacy 4-bit basic ops plus an iterative RV M-extension unit.
// Valid/ready handshake on both sides; multiply/divide retire one bit per cycle.
module rv_alu_seq #(
    parameter  int XLEN = 64,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      op_sel_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [SHW-1:0]    cnt;
    logic [2*XLEN-1:0] acc;    // mul: {partial high, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opnd;   // multiplicand or divisor magnitude
    logic [2:0]        mop;
    logic              neg_q;
    logic              neg_r;

    logic              accept;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   quick_res;
    logic              quick;
    logic              sgn1, sgn2, s1, s2;
    logic [XLEN-1:0]   mag1, mag2;

    assign accept = valid_i && ready_o;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        alu_res = '0;
        case (op_sel_i[3:0])
            4'b0000: alu_res = op1_i & op2_i;
            4'b0001: alu_res = op1_i | op2_i;
            4'b0010: alu_res = op1_i + op2_i;
            4'b0110: alu_res = op1_i - op2_i;
            4'b1100: alu_res = ~(op1_i | op2_i);
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            4'b0011: alu_res = op1_i ^ op2_i;
            4'b0100: alu_res = op1_i << op2_i[SHW-1:0];
            4'b0101: alu_res = op1_i >> op2_i[SHW-1:0];
            4'b1101: alu_res = XLEN'($signed(op1_i) >>> op2_i[SHW-1:0]);
            default: alu_res = '0;
        endcase
    end

    // Divide-by-zero and signed overflow bypass the iterative unit entirely.
    always_comb begin
        quick     = 1'b1;
        quick_res = alu_res;
        if (op_sel_i[4]) begin
            quick = 1'b0;
            if (op_sel_i[2] && op2_i == '0) begin
                quick     = 1'b1;
                quick_res = op_sel_i[1] ? op1_i : '1;
            end else if (op_sel_i[2] && !op_sel_i[0] && op1_i == SMIN && op2_i == '1) begin
                quick     = 1'b1;
                quick_res = op_sel_i[1] ? '0 : op1_i;
            end
        end
    end

    always_comb begin
        sgn1 = op_sel_i[2] ? !op_sel_i[0] : (op_sel_i[1:0] == 2'b01 || op_sel_i[1:0] == 2'b10);
        sgn2 = op_sel_i[2] ? !op_sel_i[0] : (op_sel_i[1:0] == 2'b01);
        s1   = sgn1 && op1_i[XLEN-1];
        s2   = sgn2 && op2_i[XLEN-1];
        mag1 = s1 ? -op1_i : op1_i;
        mag2 = s2 ? -op2_i : op2_i;
    end

    logic [XLEN:0]     sum;
    logic [XLEN:0]     rs;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {sum, acc[XLEN-1:1]};
        rs       = acc[2*XLEN-1:XLEN-1];
        trial    = rs - {1'b0, opnd};
        div_next = {trial[XLEN] ? rs[XLEN-1:0] : trial[XLEN-1:0], acc[XLEN-2:0], ~trial[XLEN]};
        prod     = neg_q ? -mul_next : mul_next;
        quo      = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        case (mop)
            3'b000:          final_res = prod[XLEN-1:0];
            3'b100, 3'b101:  final_res = neg_q ? -quo : quo;
            3'b110, 3'b111:  final_res = neg_r ? -rem : rem;
            default:         final_res = prod[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    ready_o <= 1'b0;
                    if (quick) begin
                        result_o <= quick_res;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt    <= SHW'(XLEN-1);
                        busy_o <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_o <= final_res;
                        busy_o   <= 1'b0;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: if (ready_i) begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mop   <= op_sel_i[2:0];
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            if (op_sel_i[2]) begin
                acc  <= {{XLEN{1'b0}}, mag1};
                opnd <= mag2;
            end else begin
                acc  <= {{XLEN{1'b0}}, mag2};
                opnd <= mag1;
            end
        end else if (state == CALC) begin
            acc <= mop[2] ? div_next : mul_next;
        end
    end

endmodule

// File: tb/tb_rv_alu_seq.sv
// Directed bench for rv_alu_seq (XLEN=64): scoreboard of expected results,
// latency and busy-cycle checks, back-pressure and mid-operation reset.
module tb_rv_alu_seq;

    localparam int XLEN = 64;
    localparam logic [63:0] ONES = '1;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [XLEN-1:0] op1_i = '0;
    logic [XLEN-1:0] op2_i = '0;
    logic [4:0]      op_sel_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    rv_alu_seq #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .op1_i(op1_i), .op2_i(op2_i), .op_sel_i(op_sel_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge and returns just after the accepting edge.
    task automatic accept(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        int waited = 0;
        @(negedge clk);
        while (!ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
        op_sel_i = op; op1_i = a; op2_i = b; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Counts cycles after the accepting edge until valid_o, then scores the result.
    task automatic wait_result(input string tag, input int lat);
        int n = 0;
        int nb = 0;
        logic [63:0] e;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (busy_o) nb++;
            if (valid_o) break;
        end
        if (!valid_o) begin
            check({tag, "_valid_timeout"}, 64'(valid_o), 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(n), 64'(lat));
            check({tag, "_busy_cycles"}, 64'(nb), 64'(lat - 1));
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_result"}, 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_result"}, result_o, e);
            end
        end
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
        @(negedge clk);
        check("ready_after_consume", 64'(ready_o), 64'd1);
        check("valid_after_consume", 64'(valid_o), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat);
        accept(op, a, b, exp);
        wait_result(tag, lat);
        consume();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        rst_i = 1'b0;

        do_op("add_wrap", 5'b00010, ONES, 64'd1, 64'd0, 1);
        do_op("sub_wrap", 5'b00110, 64'd0, 64'd1, ONES, 1);
        do_op("sltu", 5'b00111, ONES, 64'd1, 64'd0, 1);
        do_op("slt", 5'b01000, ONES, 64'd1, 64'd1, 1);
        do_op("sra", 5'b01101, SMIN, 64'h43, 64'hF000_0000_0000_0000, 1);
        do_op("srl", 5'b00101, SMIN, 64'h43, 64'h1000_0000_0000_0000, 1);
        do_op("sll", 5'b00100, 64'h3, 64'd62, 64'hC000_0000_0000_0000, 1);
        do_op("and", 5'b00000, 64'hF0F0, 64'h0FF0, 64'h00F0, 1);
        do_op("or", 5'b00001, 64'hF000, 64'h000F, 64'hF00F, 1);
        do_op("xor", 5'b00011, 64'hFF00, 64'h0FF0, 64'hF0F0, 1);
        do_op("nor", 5'b01100, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_0000, 64'h0000_0000_0000_FFFF, 1);
        do_op("undef_code", 5'b01001, 64'd5, 64'd6, 64'd0, 1);

        do_op("mulh", 5'b10001, -64'sd2, 64'd3, ONES, 65);
        do_op("mulhu", 5'b10011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        do_op("mul_bit3", 5'b11000, 64'd7, -64'sd3, -64'sd21, 65);
        do_op("mulhsu", 5'b10010, ONES, 64'd2, ONES, 65);
        do_op("div", 5'b10100, -64'sd7, 64'd2, -64'sd3, 65);
        do_op("rem", 5'b10110, -64'sd7, 64'd2, -64'sd1, 65);
        do_op("divu", 5'b10101, 64'd100, 64'd7, 64'd14, 65);
        do_op("remu", 5'b10111, 64'd100, 64'd7, 64'd2, 65);
        do_op("divu_by0", 5'b10101, 64'd1234, 64'd0, ONES, 1);
        do_op("remu_by0", 5'b10111, 64'd1234, 64'd0, 64'd1234, 1);
        do_op("rem_ovf", 5'b10110, SMIN, ONES, 64'd0, 1);
        do_op("div_ovf", 5'b10100, SMIN, ONES, SMIN, 1);

        // Back-pressure: result must hold while a new request is ignored.
        accept(5'b00010, 64'd5, 64'd6, 64'd11);
        wait_result("bp_add", 1);
        op_sel_i = 5'b00011; op1_i = 64'hAAAA; op2_i = 64'h00FF; valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result_stable", result_o, 64'd11);
            check("bp_ready_low", 64'(ready_o), 64'd0);
            check("bp_valid_high", 64'(valid_o), 64'd1);
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
        @(negedge clk);
        check("bp_ready_after_release", 64'(ready_o), 64'd1);
        check("bp_valid_after_release", 64'(valid_o), 64'd0);
        exp_q.push_back(64'hAA55);
        @(posedge clk);
        #1 valid_i = 1'b0;
        wait_result("bp_xor", 1);
        consume();

        // Reset 30 cycles into a DIVU aborts it without presenting a result.
        accept(5'b10101, ONES, 64'd3, 64'd0);
        void'(exp_q.pop_back());
        repeat (29) @(negedge clk);
        check("abort_busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_result", result_o, 64'd0);
        check("abort_ready", 64'(ready_o), 64'd1);
        check("abort_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        do_op("and_after_rst", 5'b00000, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F,
              64'h0F0F_0000_0F0F_0000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
